// File: rtl/dmem_unit.sv
// Data-memory unit behind the CPU memory stage: one load/store in flight, fixed wait-state
// latency, little-endian word array, sign/zero-extended loads and error flagging.
module dmem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp, commit;
  logic        a_wen;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr, a_wdata;
  logic [29:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic [4:0]  shamt;
  logic        range_err, align_err, f3_err, acc_err;
  logic [31:0] cur_word, shifted, load_data, wmask, wword, new_word;

  assign accept = req_valid & req_ready;

  // With zero wait states the access resolves on the accept edge, so it must see the request
  // inputs directly rather than the holding registers.
  always_comb begin
    if (state_q == StIdle) begin
      a_wen    = req_wen;
      a_funct3 = req_funct3;
      a_addr   = req_addr;
      a_wdata  = req_wdata;
    end else begin
      a_wen    = wen_q;
      a_funct3 = funct3_q;
      a_addr   = addr_q;
      a_wdata  = wdata_q;
    end
  end

  assign word_idx  = a_addr[31:2];
  assign mem_idx   = word_idx[AW-1:0];
  assign shamt     = {a_addr[1:0], 3'b000};
  assign range_err = ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
  assign cur_word  = mem[mem_idx];
  assign shifted   = cur_word >> shamt;

  always_comb begin
    align_err = 1'b0;
    case (a_funct3[1:0])
      2'b01:   align_err = a_addr[0];
      2'b10:   align_err = (a_addr[1:0] != 2'b00);
      default: align_err = 1'b0;
    endcase
    if (a_wen) f3_err = a_funct3[2] | (a_funct3[1:0] == 2'b11);
    else       f3_err = (a_funct3 == 3'b011) | (a_funct3[2:1] == 2'b11);
    acc_err = range_err | align_err | f3_err;
  end

  always_comb begin
    load_data = 32'h0;
    case (a_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = cur_word;
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // Lane mask and lane-replicated data so untouched bytes keep their old value.
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    wword = a_wdata;
    case (a_funct3[1:0])
      2'b00: begin
        wmask = 32'h0000_00FF << shamt;
        wword = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wmask = 32'h0000_FFFF << shamt;
        wword = {2{a_wdata[15:0]}};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wword = a_wdata;
      end
    endcase
    new_word = (cur_word & ~wmask) | (wword & wmask);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wen_d    = req_wen;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || a_wen) ? 32'h0 : load_data;
    end
  end

  assign commit = enter_resp & a_wen & ~acc_err & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      wen_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit) mem[mem_idx] <= new_word;
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: three instances (1, 3 and 0 wait states) sharing clock and reset,
// with a response scoreboard that also checks the response cycle.
module tb_dmem_unit;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] req_valid, req_ready, req_wen, rsp_valid, rsp_err;
  logic [2:0]    req_funct3 [NI];
  logic [31:0]   req_addr   [NI];
  logic [31:0]   req_wdata  [NI];
  logic [31:0]   rsp_rdata  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Ws = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    dmem_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(Ws)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wen   (req_wen[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[$];
  vec_t t6[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest pending expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rsp_valid[i] !== 1'b0) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected inst=%0d got rdata=%h err=%b required no response",
                   i, rsp_rdata[i], rsp_err[i]);
        end else begin
          e = sbq.pop_front();
          if (e.inst != i || rsp_rdata[i] !== e.rdata || rsp_err[i] !== e.err || cyc != e.at) begin
            errors++;
            $display("FAIL rsp inst=%0d got rdata=%h err=%b cyc=%0d required inst=%0d rdata=%h err=%b cyc=%0d",
                     i, rsp_rdata[i], rsp_err[i], cyc, e.inst, e.rdata, e.err, e.at);
          end
        end
      end
    end
  end

  task automatic drive(input int i, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_wen[i]    = wen;
    req_funct3[i] = f3;
    req_addr[i]   = addr;
    req_wdata[i]  = wdata;
  endtask

  task automatic issue(input int i, input vec_t v);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (req_ready[i] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout inst=%0d got ready=%b required 1", i, req_ready[i]);
      return;
    end
    drive(i, v.wen, v.f3, v.addr, v.wdata);
    req_valid[i] = 1'b1;
    e.inst  = i;
    e.rdata = v.rd;
    e.err   = v.err;
    e.at    = cyc + 1 + ws_of(i);
    sbq.push_back(e);
    for (int k = 0; k <= ws_of(i); k++) begin
      @(negedge clk);
      req_valid[i] = 1'b0;
      chk($sformatf("ready_busy_i%0d_k%0d", i, k), 32'(req_ready[i]), 32'd0);
    end
    @(negedge clk);
    chk($sformatf("ready_back_i%0d", i), 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int last_acc;
    exp_t e;

    // wen, funct3, addr, wdata, expected rdata, expected err
    tv.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0});
    tv.push_back('{1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0});
    tv.push_back('{1'b0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0});
    tv.push_back('{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 1'b0});
    tv.push_back('{1'b1, 3'b000, 32'h11,   32'h000000AA, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADAAEF, 1'b0});
    tv.push_back('{1'b1, 3'b001, 32'h12,   32'h00001234, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'h1234AAEF, 1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h11,   32'h0,        32'hFFFFFFAA, 1'b0});
    tv.push_back('{1'b0, 3'b001, 32'h12,   32'h0,        32'h00001234, 1'b0});
    tv.push_back('{1'b0, 3'b100, 32'h10,   32'h0,        32'h000000EF, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b1, 3'b001, 32'h21,   32'h0000FFFF, 32'h0,        1'b1});
    tv.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b0, 3'b110, 32'h10,   32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b1, 3'b010, 32'h14,   32'h11223344, 32'h0,        1'b0});
    tv.push_back('{1'b1, 3'b010, 32'h16,   32'hFFFFFFFF, 32'h0,        1'b1});
    tv.push_back('{1'b0, 3'b010, 32'h14,   32'h0,        32'h11223344, 1'b0});
    tv.push_back('{1'b1, 3'b100, 32'h14,   32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b0, 3'b010, 32'h14,   32'h0,        32'h11223344, 1'b0});
    tv.push_back('{1'b1, 3'b000, 32'h17,   32'h00000080, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h17,   32'h0,        32'hFFFFFF80, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h14,   32'h0,        32'h80223344, 1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h14,   32'h0,        32'h00000044, 1'b0});
    tv.push_back('{1'b1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0});
    tv.push_back('{1'b0, 3'b001, 32'hFFE,  32'h0,        32'hFFFFCAFE, 1'b0});

    t6.push_back('{1'b1, 3'b010, 32'h40, 32'h11111111, 32'h0,        1'b0});
    t6.push_back('{1'b1, 3'b010, 32'h44, 32'h22222222, 32'h0,        1'b0});
    t6.push_back('{1'b0, 3'b010, 32'h40, 32'h0,        32'h11111111, 1'b0});
    t6.push_back('{1'b0, 3'b010, 32'h44, 32'h0,        32'h22222222, 1'b0});
    t6.push_back('{1'b1, 3'b000, 32'h41, 32'h000000CC, 32'h0,        1'b0});
    t6.push_back('{1'b0, 3'b010, 32'h40, 32'h0,        32'h1111CC11, 1'b0});
    t6.push_back('{1'b0, 3'b001, 32'h42, 32'h0,        32'h00001111, 1'b0});
    t6.push_back('{1'b0, 3'b010, 32'h43, 32'h0,        32'h0,        1'b1});

    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NI; i++) drive(i, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ready_i%0d", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst_valid_i%0d", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst_rdata_i%0d", i), rsp_rdata[i], 32'h0);
      chk($sformatf("rst_err_i%0d", i), 32'(rsp_err[i]), 32'd0);
    end

    // Single-issue functional table on the one-wait-state instance.
    for (int n = 0; n < tv.size(); n++) issue(0, tv[n]);

    // Reset during WAIT drops an uncommitted store on the three-wait-state instance.
    issue(1, '{1'b1, 3'b010, 32'h20, 32'h00000077, 32'h0, 1'b0});
    @(negedge clk);
    drive(1, 1'b1, 3'b010, 32'h20, 32'h00000055);
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_ready", 32'(req_ready[1]), 32'd1);
    chk("rstmid_valid", 32'(rsp_valid[1]), 32'd0);
    repeat (6) @(negedge clk);
    issue(1, '{1'b0, 3'b010, 32'h20, 32'h0, 32'h00000077, 1'b0});

    // Zero wait states, req_valid held high; inputs scrambled while busy must be ignored.
    n_acc    = 0;
    last_acc = -1;
    @(negedge clk);
    for (int c = 0; c < 60 && n_acc < t6.size(); c++) begin
      req_valid[2] = 1'b1;
      if (req_ready[2] === 1'b1) begin
        if (last_acc >= 0) chk($sformatf("accept_gap_%0d", n_acc), cyc - last_acc, 32'd2);
        last_acc = cyc;
        drive(2, t6[n_acc].wen, t6[n_acc].f3, t6[n_acc].addr, t6[n_acc].wdata);
        e.inst  = 2;
        e.rdata = t6[n_acc].rd;
        e.err   = t6[n_acc].err;
        e.at    = cyc + 1;
        sbq.push_back(e);
        n_acc++;
      end else begin
        drive(2, 1'b1, 3'b010, 32'h40, 32'hBAD0BAD0);
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    chk("t6_accepts", n_acc, t6.size());
    drive(2, 1'b0, 3'b000, 32'h0, 32'h0);
    issue(2, '{1'b0, 3'b010, 32'h40, 32'h0, 32'h1111CC11, 1'b0});

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
